bunch_event_counter: RTL and testbench
======================================

Name: bunch_event_counter

Overview:
- Parametrised successor of the bunch/event counter. Runs directly on the LHC bunch clock.
- Tracks the bunch crossing within the orbit, the orbit count and the L1A event count. Resynchronises on BC0, EC0 and OC0 broadcast commands.
- Snapshots {bunch, event, orbit} on every L1A (t1) for the readout/event-builder path.
- Reports BC0 alignment errors.

Parameters:
- BX_W, 16: bunch counter width; must hold BX_PER_ORBIT-1.
- EVT_W, 24: event counter width.
- ORB_W, 32: orbit counter width.
- BX_PER_ORBIT, 3564: bunch slots per orbit; wrap point.
- BC0_OFFSET, 0: bunch value loaded on BC0; compensates TTC decode latency; must be < BX_PER_ORBIT.

Ports:
- clk  in  1  bunch clock (40.08 MHz); only clock.
- rst  in  1  asynchronous, active-low reset (assert low, async; deassert sync'd externally).
- bc0  in  1  bunch-counter-zero command, 1-cycle pulse.
- ec0  in  1  event-counter reset command, 1-cycle pulse.
- oc0  in  1  orbit-counter reset command, 1-cycle pulse.
- t1  in  1  L1A trigger, 1-cycle pulse.
- err_clr  in  1  clears sticky error flags.
- bunch_number  out  BX_W  live bunch count.
- event_number  out  EVT_W  live event count (last L1A number).
- orbit_number  out  ORB_W  live orbit count.
- trig_valid  out  1  1-cycle strobe: snapshot valid.
- trig_bunch  out  BX_W  bunch of the L1A.
- trig_event  out  EVT_W  event number assigned to the L1A.
- trig_orbit  out  ORB_W  orbit of the L1A.
- locked  out  1  at least one BC0 received since reset.
- bc0_err  out  1  sticky: BC0 arrived off expected slot.
- evt_wrap  out  1  sticky: event counter wrapped.

Behaviour:
- Reset (rst low, async): all counters, snapshot outputs, trig_valid, locked, bc0_err and evt_wrap go to 0.
- Bunch counter: increments every clk. At BX_PER_ORBIT-1 it wraps to 0 and orbit_number increments (mod 2^ORB_W).
- BC0 seen at cycle n:
  - bunch_number = BC0_OFFSET at cycle n+1; locked=1 from n+1.
  - If locked was already 1 and bunch_number at n != (BC0_OFFSET+BX_PER_ORBIT-1) mod BX_PER_ORBIT, then bc0_err=1 (sticky). The first BC0 after reset never flags.
  - BC0 does not increment orbit by itself. Orbit increments only on natural wrap, or when BC0 forces the bunch counter past the wrap point from a nonzero offset, i.e. when the counter would have wrapped at n.
- OC0: orbit_number=0 next cycle. If OC0 and an orbit increment coincide, OC0 wins (result 0).
- Event counter:
  - On t1: event_number+1, modulo 2^EVT_W; wrap from all-ones to 0 sets evt_wrap.
  - On ec0: 0.
  - ec0 and t1 in the same cycle: event_number=1, and the snapshot reports 1.
  - The first L1A after reset or EC0 is event 1.
- Snapshot: t1 at cycle n gives trig_valid=1 at n+1 (latency 1), carrying:
  - trig_bunch/trig_orbit: values present at cycle n, before any same-cycle BC0/OC0 update.
  - trig_event: the new event number.
  - Back-to-back t1 produces back-to-back strobes; no hold-off, no loss.
  - Snapshot registers hold their values between strobes.
- err_clr: clears bc0_err and evt_wrap next cycle. A new error in the same cycle wins (flag stays 1).
- t1 before lock: counted and snapshotted normally; the consumer qualifies it with locked.
- Mid-operation reset: everything returns to reset values immediately; locked must re-acquire.

Optional Feature:
- Macro: BUNCH_EVENT_COUNTER_BC0_CHECK_EN.
- Defined: BC0 alignment check as above; bc0_err is live.
- Undefined: compare logic removed; bc0_err is tied to 0. All other behaviour is unchanged.

Decomposition:
- Shared package ttc_pkg: LHC_BX_PER_ORBIT=3564, default widths, TTC command encodings.
- One natural sub-module: wrap_counter (generic width/modulo counter with load, clear, wrap strobe). Instantiated for the bunch counter and, with modulo 2^W, for the event and orbit counters.

Test Plan:
- Reset, then 3564 idle cycles with no BC0 -> bunch_number wraps 3563->0; orbit_number=1; locked=0.
- bc0 at bunch 100 (unlocked), then bc0 exactly every 3564 cycles -> bunch_number=0 after each; locked=1; bc0_err stays 0. Then one bc0 at bunch 1000 -> bc0_err=1; err_clr -> bc0_err=0.
- Three t1 on consecutive cycles at bunch 10/11/12 -> trig_valid high for 3 cycles, trig_event 1,2,3, trig_bunch 10,11,12.
- ec0 and t1 in the same cycle with event_number=57 -> trig_event=1, event_number=1.
- EVT_W=4: 16 t1 pulses -> event_number 15 then 0; evt_wrap=1.
- t1 coincident with bc0 at bunch 3563 and with oc0 -> trig_bunch=3563, trig_orbit=the pre-reset orbit value; next cycle bunch_number=0, orbit_number=0.

Source files
------------

// File: rtl/ttc_pkg.sv
// Shared TTC definitions: LHC orbit geometry, default counter widths and
// broadcast command encodings used by the timing/trigger front-end blocks.
package ttc_pkg;

  localparam int unsigned LHC_BX_PER_ORBIT = 3564;
  localparam int unsigned DEF_BX_W         = 16;
  localparam int unsigned DEF_EVT_W        = 24;
  localparam int unsigned DEF_ORB_W        = 32;
  localparam int unsigned TTC_CMD_W        = 8;

  // Broadcast command encodings as delivered by the TTC decoder
  typedef enum logic [TTC_CMD_W-1:0] {
    TTC_CMD_NONE   = 8'h00,
    TTC_CMD_BC0    = 8'h01,
    TTC_CMD_EC0    = 8'h02,
    TTC_CMD_RESYNC = 8'h04,
    TTC_CMD_OC0    = 8'h08
  } ttc_cmd_e;

  // True for commands that realign one of the bunch/event/orbit counters
  function automatic logic is_counter_cmd(input ttc_cmd_e cmd);
    return (cmd == TTC_CMD_BC0) || (cmd == TTC_CMD_EC0) || (cmd == TTC_CMD_OC0);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Generic wrapping counter with synchronous load.
//   clk, rst (async, active-low)
//   inc       : advance by one; wraps from MAX_VAL to 0
//   load      : load load_val (takes priority over inc)
//   load_val  : value loaded on load
//   count     : registered count
//   wrap_c    : combinational, high when inc is asserted at MAX_VAL
//               (asserted even if a load overrides the increment)
module wrap_counter #(
  parameter int unsigned   W       = 8,
  parameter logic [W-1:0]  MAX_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         wrap_c
);

  logic at_max;

  assign at_max = (count == MAX_VAL);
  assign wrap_c = inc & at_max;

  // Count register: load beats increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= at_max ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/bunch_event_counter.sv
// Bunch / orbit / L1A event counter running on the LHC bunch clock.
// Resynchronises on BC0/EC0/OC0, snapshots {bunch, event, orbit} on each L1A
// and flags BC0 misalignment and event-counter wrap.
//
// Optional build macro BUNCH_EVENT_COUNTER_BC0_CHECK_EN enables the BC0
// alignment check; when undefined bc0_err is tied to 0.
//
// Ports:
//   clk, rst (async, active-low)
//   bc0, ec0, oc0 : broadcast resync commands (1-cycle pulses)
//   t1            : L1A trigger (1-cycle pulse)
//   err_clr       : clears the sticky error flags
//   bunch_number, event_number, orbit_number : live counters
//   trig_valid, trig_bunch, trig_event, trig_orbit : L1A snapshot (latency 1)
//   locked        : a BC0 has been seen since reset
//   bc0_err       : sticky BC0 misalignment
//   evt_wrap      : sticky event-counter wrap
module bunch_event_counter
  import ttc_pkg::*;
#(
  parameter int unsigned BX_W         = DEF_BX_W,
  parameter int unsigned EVT_W        = DEF_EVT_W,
  parameter int unsigned ORB_W        = DEF_ORB_W,
  parameter int unsigned BX_PER_ORBIT = LHC_BX_PER_ORBIT,
  parameter int unsigned BC0_OFFSET   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bc0,
  input  logic             ec0,
  input  logic             oc0,
  input  logic             t1,
  input  logic             err_clr,
  output logic [BX_W-1:0]  bunch_number,
  output logic [EVT_W-1:0] event_number,
  output logic [ORB_W-1:0] orbit_number,
  output logic             trig_valid,
  output logic [BX_W-1:0]  trig_bunch,
  output logic [EVT_W-1:0] trig_event,
  output logic [ORB_W-1:0] trig_orbit,
  output logic             locked,
  output logic             bc0_err,
  output logic             evt_wrap
);

  localparam logic [BX_W-1:0] BX_MAX  = BX_W'(BX_PER_ORBIT - 1);
  localparam logic [BX_W-1:0] BX_LOAD = BX_W'(BC0_OFFSET);

  logic             bx_wrap;
  logic             evt_wrap_c;
  logic             evt_wrap_set;
  logic [EVT_W-1:0] event_nxt;

  // Bunch counter: free-running, BC0 loads the offset. bx_wrap still fires
  // when a BC0 lands on the wrap slot, so the orbit keeps advancing.
  wrap_counter #(
    .W       (BX_W),
    .MAX_VAL (BX_MAX)
  ) u_bx_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (1'b1),
    .load     (bc0),
    .load_val (BX_LOAD),
    .count    (bunch_number),
    .wrap_c   (bx_wrap)
  );

  // Orbit counter: OC0 load wins over a coincident wrap increment
  wrap_counter #(
    .W       (ORB_W),
    .MAX_VAL ('1)
  ) u_orb_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (bx_wrap),
    .load     (oc0),
    .load_val ('0),
    .count    (orbit_number),
    .wrap_c   ()
  );

  // Event counter: EC0 with a coincident L1A loads 1 so that L1A is event 1
  wrap_counter #(
    .W       (EVT_W),
    .MAX_VAL ('1)
  ) u_evt_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (t1),
    .load     (ec0),
    .load_val (EVT_W'(t1)),
    .count    (event_number),
    .wrap_c   (evt_wrap_c)
  );

  // Event number the current L1A will be assigned
  assign event_nxt    = ec0 ? EVT_W'(1) : event_number + EVT_W'(1);
  // A wrap that coincides with EC0 never happens in the counter
  assign evt_wrap_set = evt_wrap_c & ~ec0;

  // L1A snapshot: pre-update bunch/orbit, post-update event number
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_valid <= 1'b0;
      trig_bunch <= '0;
      trig_event <= '0;
      trig_orbit <= '0;
    end else begin
      trig_valid <= t1;
      if (t1) begin
        trig_bunch <= bunch_number;
        trig_event <= event_nxt;
        trig_orbit <= orbit_number;
      end
    end
  end

  // Lock and sticky event-wrap flag; a new error beats err_clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked   <= 1'b0;
      evt_wrap <= 1'b0;
    end else begin
      locked   <= locked | bc0;
      evt_wrap <= evt_wrap_set | (evt_wrap & ~err_clr);
    end
  end

`ifdef BUNCH_EVENT_COUNTER_BC0_CHECK_EN
  localparam logic [BX_W-1:0] BX_EXP =
    BX_W'((BC0_OFFSET + BX_PER_ORBIT - 1) % BX_PER_ORBIT);

  logic bc0_err_set;

  // Only a BC0 after lock can be misaligned
  assign bc0_err_set = bc0 & locked & (bunch_number != BX_EXP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bc0_err <= 1'b0;
    end else begin
      bc0_err <= bc0_err_set | (bc0_err & ~err_clr);
    end
  end
`else
  assign bc0_err = 1'b0;
`endif

endmodule

// File: tb/tb_bunch_event_counter.sv
// Directed self-checking bench for bunch_event_counter. A second instance
// with a 4-bit event counter shares all stimulus and covers event wrap.
module tb_bunch_event_counter;

  logic clk = 1'b0;
  logic rst, bc0, ec0, oc0, t1, err_clr;

  logic [15:0] bunch_number, trig_bunch;
  logic [23:0] event_number, trig_event;
  logic [31:0] orbit_number, trig_orbit;
  logic        trig_valid, locked, bc0_err, evt_wrap;

  logic [15:0] s_bunch_number, s_trig_bunch;
  logic [3:0]  s_event_number, s_trig_event;
  logic [31:0] s_orbit_number, s_trig_orbit;
  logic        s_trig_valid, s_locked, s_bc0_err, s_evt_wrap;

  int vectors = 0;
  int miscompares = 0;
  logic exp_err;

  always #5 clk = ~clk;

  bunch_event_counter dut (
    .clk(clk), .rst(rst), .bc0(bc0), .ec0(ec0), .oc0(oc0), .t1(t1),
    .err_clr(err_clr),
    .bunch_number(bunch_number), .event_number(event_number),
    .orbit_number(orbit_number), .trig_valid(trig_valid),
    .trig_bunch(trig_bunch), .trig_event(trig_event), .trig_orbit(trig_orbit),
    .locked(locked), .bc0_err(bc0_err), .evt_wrap(evt_wrap)
  );

  bunch_event_counter #(.EVT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bc0(bc0), .ec0(ec0), .oc0(oc0), .t1(t1),
    .err_clr(err_clr),
    .bunch_number(s_bunch_number), .event_number(s_event_number),
    .orbit_number(s_orbit_number), .trig_valid(s_trig_valid),
    .trig_bunch(s_trig_bunch), .trig_event(s_trig_event),
    .trig_orbit(s_trig_orbit),
    .locked(s_locked), .bc0_err(s_bc0_err), .evt_wrap(s_evt_wrap)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef BUNCH_EVENT_COUNTER_BC0_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b0; bc0 = 1'b0; ec0 = 1'b0; oc0 = 1'b0; t1 = 1'b0; err_clr = 1'b0;
    cyc(2);
    chk("rst_bunch", 64'(bunch_number), 64'd0);
    chk("rst_event", 64'(event_number), 64'd0);
    chk("rst_orbit", 64'(orbit_number), 64'd0);
    chk("rst_valid", 64'(trig_valid), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_evt_wrap", 64'(evt_wrap), 64'd0);
    rst = 1'b1;

    // Free-run one orbit with no BC0
    cyc(3563);
    chk("run_bunch_max", 64'(bunch_number), 64'd3563);
    chk("run_orbit0", 64'(orbit_number), 64'd0);
    cyc(1);
    chk("run_bunch_wrap", 64'(bunch_number), 64'd0);
    chk("run_orbit1", 64'(orbit_number), 64'd1);
    chk("run_unlocked", 64'(locked), 64'd0);

    // First BC0 at bunch 100 while unlocked
    cyc(100);
    bc0 = 1'b1; cyc(1); bc0 = 1'b0;
    chk("bc0a_bunch", 64'(bunch_number), 64'd0);
    chk("bc0a_locked", 64'(locked), 64'd1);
    chk("bc0a_err", 64'(bc0_err), 64'd0);
    chk("bc0a_orbit", 64'(orbit_number), 64'd1);

    // Two aligned BC0s, each on the wrap slot
    cyc(3563);
    bc0 = 1'b1; cyc(1); bc0 = 1'b0;
    chk("bc0b_bunch", 64'(bunch_number), 64'd0);
    chk("bc0b_orbit", 64'(orbit_number), 64'd2);
    chk("bc0b_err", 64'(bc0_err), 64'd0);
    cyc(3563);
    bc0 = 1'b1; cyc(1); bc0 = 1'b0;
    chk("bc0c_orbit", 64'(orbit_number), 64'd3);
    chk("bc0c_err", 64'(bc0_err), 64'd0);

    // Misaligned BC0 at bunch 1000, then clear
    cyc(1000);
    bc0 = 1'b1; cyc(1); bc0 = 1'b0;
    chk("bc0d_bunch", 64'(bunch_number), 64'd0);
    chk("bc0d_orbit", 64'(orbit_number), 64'd3);
    chk("bc0d_err", 64'(bc0_err), 64'(exp_err));
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;    // bunch 1
    chk("errclr_bc0", 64'(bc0_err), 64'd0);

    // Three back-to-back L1As at bunch 10/11/12
    cyc(9);                                     // bunch 10
    chk("t1_pre_bunch", 64'(bunch_number), 64'd10);
    t1 = 1'b1;
    cyc(1);
    chk("t1a_valid", 64'(trig_valid), 64'd1);
    chk("t1a_event", 64'(trig_event), 64'd1);
    chk("t1a_bunch", 64'(trig_bunch), 64'd10);
    chk("t1a_orbit", 64'(trig_orbit), 64'd3);
    cyc(1);
    chk("t1b_valid", 64'(trig_valid), 64'd1);
    chk("t1b_event", 64'(trig_event), 64'd2);
    chk("t1b_bunch", 64'(trig_bunch), 64'd11);
    cyc(1);
    chk("t1c_valid", 64'(trig_valid), 64'd1);
    chk("t1c_event", 64'(trig_event), 64'd3);
    chk("t1c_bunch", 64'(trig_bunch), 64'd12);
    t1 = 1'b0;
    cyc(1);                                     // bunch 14
    chk("t1_idle_valid", 64'(trig_valid), 64'd0);
    chk("t1_hold_bunch", 64'(trig_bunch), 64'd12);
    chk("t1_hold_event", 64'(trig_event), 64'd3);
    chk("t1_live_event", 64'(event_number), 64'd3);

    // Bring event to 57, then EC0 + L1A together
    t1 = 1'b1; cyc(54); t1 = 1'b0;              // bunch 68
    chk("ev57", 64'(event_number), 64'd57);
    chk("ev57_small_wrap", 64'(s_evt_wrap), 64'd1);
    ec0 = 1'b1; t1 = 1'b1; cyc(1); ec0 = 1'b0; t1 = 1'b0;  // bunch 69
    chk("ec0t1_trig_event", 64'(trig_event), 64'd1);
    chk("ec0t1_event", 64'(event_number), 64'd1);
    chk("ec0t1_valid", 64'(trig_valid), 64'd1);

    // 4-bit event counter wrap after EC0 + err_clr
    ec0 = 1'b1; err_clr = 1'b1; cyc(1); ec0 = 1'b0; err_clr = 1'b0;  // bunch 70
    chk("w_ev0", 64'(s_event_number), 64'd0);
    chk("w_clr", 64'(s_evt_wrap), 64'd0);
    t1 = 1'b1;
    cyc(15);
    chk("w_ev15", 64'(s_event_number), 64'd15);
    chk("w_nowrap", 64'(s_evt_wrap), 64'd0);
    cyc(1);                                     // bunch 86
    t1 = 1'b0;
    chk("w_ev0b", 64'(s_event_number), 64'd0);
    chk("w_wrap", 64'(s_evt_wrap), 64'd1);
    chk("w_trig_event", 64'(s_trig_event), 64'd0);
    chk("w_wide_event", 64'(event_number), 64'd16);
    chk("w_wide_nowrap", 64'(evt_wrap), 64'd0);

    // L1A coincident with BC0 on the wrap slot and OC0
    cyc(3477);
    chk("co_pre_bunch", 64'(bunch_number), 64'd3563);
    chk("co_pre_orbit", 64'(orbit_number), 64'd3);
    t1 = 1'b1; bc0 = 1'b1; oc0 = 1'b1;
    cyc(1);
    t1 = 1'b0; bc0 = 1'b0; oc0 = 1'b0;
    chk("co_trig_bunch", 64'(trig_bunch), 64'd3563);
    chk("co_trig_orbit", 64'(trig_orbit), 64'd3);
    chk("co_trig_event", 64'(trig_event), 64'd17);
    chk("co_bunch", 64'(bunch_number), 64'd0);
    chk("co_orbit", 64'(orbit_number), 64'd0);
    chk("co_err", 64'(bc0_err), 64'd0);

    // Asynchronous mid-operation reset
    cyc(5);
    #2 rst = 1'b0;
    #1;
    chk("mrst_bunch", 64'(bunch_number), 64'd0);
    chk("mrst_locked", 64'(locked), 64'd0);
    chk("mrst_event", 64'(event_number), 64'd0);
    chk("mrst_trig_bunch", 64'(trig_bunch), 64'd0);
    chk("mrst_small_wrap", 64'(s_evt_wrap), 64'd0);
    cyc(1);
    rst = 1'b1;
    cyc(3);
    chk("mrst_run_bunch", 64'(bunch_number), 64'd3);
    chk("mrst_run_locked", 64'(locked), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
